// File: rtl/axi_tap_pkg.sv
// Shared types and helpers for the AXI channel taps (write side today, read side later).
package axi_tap_pkg;

  typedef enum logic [1:0] {META, DATA, STRB} tap_state_e;

  localparam logic [2:0] TAG_STREAM = 3'b011;
  localparam logic [2:0] TAG_ERR    = 3'b111;

  // Payload bits left in a stream word once the type tag occupies the MSBs.
  function automatic int unsigned chunk_bits(int unsigned data_width, int unsigned tag_width);
    return data_width - tag_width;
  endfunction

  function automatic int unsigned strb_words(int unsigned max_burst, int unsigned strb_w,
                                             int unsigned chunk);
    return (max_burst * strb_w + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry valid/ready output register; the caller only raises load when load_ok is high.
module stream_out_reg #(
  parameter int unsigned WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  output logic             load_ok,
  output logic             valid,
  input  logic             ready,
  output logic             last,
  output logic [WIDTH-1:0] data
);

  assign load_ok = !valid || ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      last  <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      last  <= load_last;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_w_stream_tap.sv
// AXI W-channel tap: forwards beats unchanged and mirrors each burst as meta, data and
// packed-strobe words onto a registered stream.
module axi_w_stream_tap
  import axi_tap_pkg::*;
#(
  parameter int unsigned                   DATA_WIDTH        = 128,
  parameter int unsigned                   ID_WIDTH          = 32,
  parameter int unsigned                   USER_WIDTH        = 64,
  parameter int unsigned                   STREAM_TYPE_WIDTH = 3,
  parameter logic [STREAM_TYPE_WIDTH-1:0]  STREAM_TYPE       = TAG_STREAM,
  parameter logic [STREAM_TYPE_WIDTH-1:0]  ERR_TYPE          = TAG_ERR,
  parameter int unsigned                   MAX_BURST         = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    grant,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic                    in_progress,
  output logic                    overflow,
  input  logic [ID_WIDTH-1:0]     AXIS_wid,
  input  logic [DATA_WIDTH-1:0]   AXIS_wdata,
  input  logic [DATA_WIDTH/8-1:0] AXIS_wstrb,
  input  logic                    AXIS_wlast,
  input  logic [USER_WIDTH-1:0]   AXIS_wuser,
  input  logic                    AXIS_wvalid,
  output logic                    AXIS_wready,
  output logic [ID_WIDTH-1:0]     AXIM_wid,
  output logic [DATA_WIDTH-1:0]   AXIM_wdata,
  output logic [DATA_WIDTH/8-1:0] AXIM_wstrb,
  output logic                    AXIM_wlast,
  output logic [USER_WIDTH-1:0]   AXIM_wuser,
  output logic                    AXIM_wvalid,
  input  logic                    AXIM_wready
);

  localparam int unsigned STRB_W     = DATA_WIDTH / 8;
  localparam int unsigned CHUNK      = chunk_bits(DATA_WIDTH, STREAM_TYPE_WIDTH);
  localparam int unsigned STRB_WORDS = strb_words(MAX_BURST, STRB_W, CHUNK);
  localparam int unsigned STRB_BITS  = MAX_BURST * STRB_W;
  localparam int unsigned PAD_BITS   = STRB_WORDS * CHUNK;
  localparam int unsigned CntW       = $clog2(MAX_BURST + 1);
  localparam int unsigned IdxW       = (STRB_WORDS > 1) ? $clog2(STRB_WORDS) : 1;

  tap_state_e             state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [STRB_BITS-1:0]   strb_q, strb_d;
  logic                   ovf_q, ovf_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic                   load_ok, fire, load, load_last;
  logic [DATA_WIDTH-1:0]  load_data;
  logic [PAD_BITS-1:0]    strb_pad;
  logic [CHUNK-1:0]       chunk;

  assign AXIM_wid    = AXIS_wid;
  assign AXIM_wdata  = AXIS_wdata;
  assign AXIM_wstrb  = AXIS_wstrb;
  assign AXIM_wlast  = AXIS_wlast;
  assign AXIM_wuser  = AXIS_wuser;
  assign overflow    = ovf_q;
  assign in_progress = (state_q != META) || m_valid;
  // Zero-extended so the final chunk reads zeros past the captured strobes.
  assign strb_pad    = PAD_BITS'(strb_q);

  always_comb begin
    chunk = '0;
    for (int i = 0; i < STRB_WORDS; i++) begin
      if (idx_q == IdxW'(i)) chunk = strb_pad[i*CHUNK +: CHUNK];
    end
  end

  always_comb begin
    fire        = grant && load_ok && !reset;
    state_d     = state_q;
    cnt_d       = cnt_q;
    strb_d      = strb_q;
    ovf_d       = ovf_q;
    idx_d       = idx_q;
    load        = 1'b0;
    load_last   = 1'b0;
    load_data   = '0;
    AXIS_wready = 1'b0;
    AXIM_wvalid = 1'b0;
    unique case (state_q)
      META: begin
        if (fire && AXIS_wvalid) begin
          load                                          = 1'b1;
          load_data[DATA_WIDTH-1 -: STREAM_TYPE_WIDTH] = STREAM_TYPE;
          load_data[ID_WIDTH-1:0]                       = AXIS_wid;
          state_d                                       = DATA;
        end
      end
      DATA: begin
        AXIM_wvalid = AXIS_wvalid && fire;
        AXIS_wready = AXIM_wready && fire;
        if (AXIS_wvalid && AXIM_wready && fire) begin
          load      = 1'b1;
          load_data = AXIS_wdata;
          if (cnt_q < CntW'(MAX_BURST)) begin
            for (int b = 0; b < MAX_BURST; b++) begin
              if (cnt_q == CntW'(b)) strb_d[b*STRB_W +: STRB_W] = AXIS_wstrb;
            end
            cnt_d = cnt_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
          if (AXIS_wlast) begin
            state_d = STRB;
            idx_d   = '0;
          end
        end
      end
      STRB: begin
        if (fire) begin
          load                                          = 1'b1;
          load_data[DATA_WIDTH-1 -: STREAM_TYPE_WIDTH] = ovf_q ? ERR_TYPE : STREAM_TYPE;
          load_data[CHUNK-1:0]                          = chunk;
          if (idx_q == IdxW'(STRB_WORDS - 1)) begin
            load_last = 1'b1;
            state_d   = META;
            cnt_d     = '0;
            strb_d    = '0;
            ovf_d     = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = META;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= META;
      cnt_q   <= '0;
      strb_q  <= '0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      strb_q  <= strb_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  stream_out_reg #(
    .WIDTH(DATA_WIDTH)
  ) u_out (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_data(load_data),
    .load_last(load_last),
    .load_ok  (load_ok),
    .valid    (m_valid),
    .ready    (m_ready),
    .last     (m_last),
    .data     (m_data)
  );

endmodule

// File: tb/tb_axi_w_stream_tap.sv
// Directed and randomized bench for axi_w_stream_tap against a transaction-level record model.
`timescale 1ns/1ps
module tb_axi_w_stream_tap;

  localparam int DW  = 128;
  localparam int IW  = 32;
  localparam int UW  = 64;
  localparam int SW  = DW / 8;
  localparam int MB  = 16;
  localparam int CH  = DW - 3;
  localparam int NSW = 3;

  logic          clk = 1'b0;
  logic          reset, grant, m_valid, m_ready, m_last, in_progress, overflow;
  logic [DW-1:0] m_data;
  logic [IW-1:0] AXIS_wid, AXIM_wid;
  logic [DW-1:0] AXIS_wdata, AXIM_wdata;
  logic [SW-1:0] AXIS_wstrb, AXIM_wstrb;
  logic          AXIS_wlast, AXIM_wlast, AXIS_wvalid, AXIM_wvalid, AXIS_wready, AXIM_wready;
  logic [UW-1:0] AXIS_wuser, AXIM_wuser;

  always #5 clk = ~clk;

  axi_w_stream_tap dut (
    .clk        (clk),
    .reset      (reset),
    .grant      (grant),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .m_data     (m_data),
    .in_progress(in_progress),
    .overflow   (overflow),
    .AXIS_wid   (AXIS_wid),
    .AXIS_wdata (AXIS_wdata),
    .AXIS_wstrb (AXIS_wstrb),
    .AXIS_wlast (AXIS_wlast),
    .AXIS_wuser (AXIS_wuser),
    .AXIS_wvalid(AXIS_wvalid),
    .AXIS_wready(AXIS_wready),
    .AXIM_wid   (AXIM_wid),
    .AXIM_wdata (AXIM_wdata),
    .AXIM_wstrb (AXIM_wstrb),
    .AXIM_wlast (AXIM_wlast),
    .AXIM_wuser (AXIM_wuser),
    .AXIM_wvalid(AXIM_wvalid),
    .AXIM_wready(AXIM_wready)
  );

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  beat_t bq[$];
  word_t expq[$];

  int n_checks = 0;
  int n_pass   = 0;
  int rdy_mode = 0;  // 0: always ready, 1: toggle, 2: random
  int wr_mode  = 0;  // 0: AXIM always ready, 1: random
  int gnt_mode = 0;  // 0: grant held by the sequence, 1: random
  int cur_beats = 0;
  bit ovf_hold = 0;
  bit hold_prev = 0, nogrant_prev = 0, mv_left = 0, b2b_check = 0, last_taken_prev = 0;
  logic [DW+1:0] held;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Queue a burst's W beats and append its expected stream record.
  task automatic queue_burst(input int n, input logic [IW-1:0] id, input bit ones);
    logic [MB*SW-1:0] sv;
    logic [NSW*CH-1:0] pad;
    beat_t b;
    word_t w;
    sv = '0;
    w.data = '0;
    w.data[DW-1 -: 3] = 3'b011;
    w.data[IW-1:0] = id;
    w.last = 1'b0;
    expq.push_back(w);
    for (int i = 0; i < n; i++) begin
      b.id   = id;
      b.data = {$urandom, $urandom, $urandom, $urandom};
      b.strb = ones ? {SW{1'b1}} : SW'($urandom);
      b.last = (i == n - 1);
      b.user = {$urandom, $urandom};
      bq.push_back(b);
      w.data = b.data;
      w.last = 1'b0;
      expq.push_back(w);
      if (i < MB) sv[i*SW +: SW] = b.strb;
    end
    pad = {{(NSW*CH - MB*SW){1'b0}}, sv};
    for (int k = 0; k < NSW; k++) begin
      w.data = {(n > MB) ? 3'b111 : 3'b011, pad[k*CH +: CH]};
      w.last = (k == NSW - 1);
      expq.push_back(w);
    end
  endtask

  task automatic drive();
    if (bq.size() > 0) begin
      AXIS_wvalid = 1'b1;
      AXIS_wid    = bq[0].id;
      AXIS_wdata  = bq[0].data;
      AXIS_wstrb  = bq[0].strb;
      AXIS_wlast  = bq[0].last;
      AXIS_wuser  = bq[0].user;
    end else begin
      AXIS_wvalid = 1'b0;
    end
    if (rdy_mode == 1) m_ready = ~m_ready;
    else if (rdy_mode == 2) m_ready = 1'($urandom_range(0, 1));
    else m_ready = 1'b1;
    AXIM_wready = (wr_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    if (gnt_mode == 1) grant = ($urandom_range(0, 3) != 0);
  endtask

  task automatic cyc();
    bit hs;
    beat_t b;
    word_t w;
    hs = 1'b0;
    drive();
    @(negedge clk);
    if (!reset) begin
      hs = AXIS_wvalid && AXIS_wready;
      chk("pass_through", {AXIM_wid, AXIM_wdata, AXIM_wstrb, AXIM_wlast, AXIM_wuser},
          {AXIS_wid, AXIS_wdata, AXIS_wstrb, AXIS_wlast, AXIS_wuser});
      chk("w_handshake", AXIM_wvalid && AXIM_wready, hs);
      if (!grant) chk("gap_quiet", {AXIM_wvalid, AXIS_wready}, 2'b00);
      if (m_valid && !m_ready) chk("bp_stall_wready", AXIS_wready, 0);
      if (hold_prev) chk("hold_stable", {m_valid, m_last, m_data}, held);
      if (nogrant_prev) chk("gap_no_word", m_valid, mv_left);
      if (b2b_check && last_taken_prev && expq.size() > 0) chk("b2b_no_idle", m_valid, 1);
      if (m_valid && m_last) ovf_hold = 1'b0;
      chk("overflow", overflow, (cur_beats > MB) || ovf_hold);
      if (m_valid) chk("in_progress_busy", in_progress, 1);
      else if (expq.size() == 0) chk("in_progress_idle", in_progress, 0);
      if (m_valid && m_ready) begin
        if (expq.size() == 0) begin
          chk("extra_word", m_valid, 0);
        end else begin
          w = expq.pop_front();
          chk("word_data", m_data, w.data);
          chk("word_last", m_last, w.last);
        end
      end
      hold_prev       = m_valid && !m_ready;
      held            = {m_valid, m_last, m_data};
      nogrant_prev    = !grant;
      mv_left         = m_valid && !m_ready;
      last_taken_prev = m_valid && m_ready && m_last;
    end
    @(posedge clk);
    #1;
    if (hs) begin
      b = bq.pop_front();
      cur_beats++;
      if (b.last) begin
        ovf_hold  = (cur_beats > MB);
        cur_beats = 0;
      end
    end
  endtask

  task automatic run_done(input int bound);
    int c;
    c = 0;
    while ((expq.size() > 0 || bq.size() > 0) && c < bound) begin
      cyc();
      c++;
    end
    chk("record_complete", expq.size() + bq.size(), 0);
    repeat (2) cyc();
  endtask

  task automatic run_until_beats(input int n);
    int c;
    c = 0;
    while (cur_beats < n && c < 100) begin
      cyc();
      c++;
    end
    chk("reach_beat", cur_beats, n);
  endtask

  initial begin
    reset       = 1'b1;
    grant       = 1'b1;
    m_ready     = 1'b1;
    AXIM_wready = 1'b1;
    AXIS_wvalid = 1'b1;
    AXIS_wid    = '0;
    AXIS_wdata  = '0;
    AXIS_wstrb  = '0;
    AXIS_wlast  = 1'b0;
    AXIS_wuser  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wready", AXIS_wready, 0);
    chk("rst_axim_wvalid", AXIM_wvalid, 0);
    chk("rst_stream", {m_valid, m_last, m_data}, 0);
    chk("rst_flags", {in_progress, overflow}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 4-beat burst, full strobes, sink always ready
    queue_burst(4, 32'h5, 1'b1);
    run_done(200);

    // same burst with the sink toggling ready
    rdy_mode = 1;
    queue_burst(4, 32'h5, 1'b1);
    run_done(200);
    rdy_mode = 0;

    // 18 beats: two past the strobe capacity
    queue_burst(18, 32'h33, 1'b0);
    run_done(300);

    // grant withdrawn for 5 cycles after beat 2
    queue_burst(6, 32'h44, 1'b0);
    run_until_beats(2);
    grant = 1'b0;
    repeat (5) cyc();
    grant = 1'b1;
    run_done(200);

    // reset mid-burst after beat 1, then a 1-beat burst
    queue_burst(4, 32'h55, 1'b0);
    run_until_beats(1);
    reset = 1'b1;
    drive();
    @(negedge clk);
    chk("midrst_wready", AXIS_wready, 0);
    chk("midrst_axim_wvalid", AXIM_wvalid, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bq.delete();
    expq.delete();
    cur_beats = 0;
    ovf_hold = 1'b0;
    hold_prev = 1'b0;
    nogrant_prev = 1'b0;
    last_taken_prev = 1'b0;
    drive();
    @(negedge clk);
    chk("postrst_m_valid", m_valid, 0);
    chk("postrst_in_progress", in_progress, 0);
    chk("postrst_overflow", overflow, 0);
    chk("postrst_wready", AXIS_wready, 0);
    @(posedge clk);
    #1;
    queue_burst(1, 32'h66, 1'b0);
    run_done(200);

    // back-to-back bursts, wvalid held high
    b2b_check = 1'b1;
    queue_burst(3, 32'h1, 1'b0);
    queue_burst(2, 32'h2, 1'b0);
    run_done(200);
    b2b_check = 1'b0;

    // randomized traffic with random sink, AXIM ready and grant
    rdy_mode = 2;
    wr_mode  = 1;
    gnt_mode = 1;
    for (int t = 0; t < 8; t++) begin
      queue_burst($urandom_range(1, 20), $urandom, 1'b0);
      if (t % 2 == 1) run_done(2000);
    end
    rdy_mode = 0;
    wr_mode  = 0;
    gnt_mode = 0;
    grant    = 1'b1;
    run_done(2000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
